// File: rtl/axistream_unpack_pkg.sv
// Shared definitions for the wide-to-narrow AXI-Stream unpacker.
// Default geometry and slice-ordering helper.
package axistream_unpack_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_PACK   = 4;

  // Output order position at which data slice `pos` is emitted.
  function automatic int slice_pos(
    input int pos,
    input int num_pack,
    input bit big_endian
  );
    return big_endian ? num_pack - 1 - pos : pos;
  endfunction

endpackage

// File: rtl/axistream_unpack_if.sv
// AXI-Stream bundle used for both the wide source
// and the narrow destination side of the unpacker.
interface axistream_unpack_if
  import axistream_unpack_pkg::*;
#(
  parameter int W = DEF_DATA_WIDTH
);
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;
  logic         tlast;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axistream_unpack.sv
// Splits one wide AXI-Stream word into NUM_PACK narrow words,
// reloading on the last slice so the output never bubbles.
module axistream_unpack
  import axistream_unpack_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_PACK   = DEF_NUM_PACK,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  axistream_unpack_if.slave  src,
  axistream_unpack_if.master dest
);

  localparam int IW = $clog2(NUM_PACK);
  localparam int WW = DATA_WIDTH * NUM_PACK;
  localparam logic [IW-1:0] LAST = IW'(NUM_PACK - 1);

  logic                  full;
  logic [IW-1:0]         idx;
  logic [WW-1:0]         data_q;
  logic                  tlast_q;
  logic                  last_slice;
  logic                  src_hs;
  logic                  dest_hs;
  logic [DATA_WIDTH-1:0] slice;

  assign last_slice  = (idx == LAST);
  assign src.tready  = rst && (!full || (dest.tready && last_slice));
  assign dest.tvalid = full && rst;
  assign src_hs      = src.tvalid && src.tready;
  assign dest_hs     = dest.tvalid && dest.tready;
  assign dest.tlast  = full && tlast_q && last_slice;
  assign dest.tdata  = slice;

  always_comb begin
    slice = '0;
    for (int i = 0; i < NUM_PACK; i++) begin
      if (idx == IW'(slice_pos(i, NUM_PACK, BIG_ENDIAN)))
        slice = data_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // A reload wins over the final drain so the next word follows directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
      idx  <= '0;
    end else if (src_hs) begin
      full <= 1'b1;
      idx  <= '0;
    end else if (dest_hs && !last_slice) begin
      idx  <= idx + 1'b1;
    end else if (dest_hs) begin
      full <= 1'b0;
      idx  <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (src_hs) begin
      data_q  <= src.tdata;
      tlast_q <= src.tlast;
    end
  end

endmodule
